// File: rtl/stage_sched_if.sv
// stage_sched_if: control/status bundle between the frame sequencer and its
// requester. master drives start/abort/done/table, slave is the sequencer.
interface stage_sched_if #(
   parameter int NSTG = 10,
   parameter int RAMS = 4
);
   logic                 iSTART;
   logic                 iABORT;
   logic [NSTG-1:0]      iDONE;
   logic [NSTG*RAMS-1:0] iOWN_TBL;
   logic [NSTG-1:0]      oENA;
   logic [3:0]           oSEL;
   logic [RAMS-1:0]      oOWN;
   logic                 oBUSY;
   logic                 oFRAME_DONE;
   logic                 oERR;
   logic                 oTIMEOUT;

   modport master (
      output iSTART, iABORT, iDONE, iOWN_TBL,
      input  oENA, oSEL, oOWN, oBUSY, oFRAME_DONE, oERR, oTIMEOUT
   );

   modport slave (
      input  iSTART, iABORT, iDONE, iOWN_TBL,
      output oENA, oSEL, oOWN, oBUSY, oFRAME_DONE, oERR, oTIMEOUT
   );
endinterface

// File: rtl/stage_sched.sv
// stage_sched: launches NSTG stages in order with a one-cycle gap between them.
// Optional per-stage watchdog is enabled by defining STAGE_WDT_EN.
module stage_sched #(
   parameter int          NSTG      = 10,
   parameter int          RAMS      = 4,
   parameter logic [23:0] WDT_LIMIT = 24'hFFFFFF
) (
   input logic          iCLK,
   input logic          iRST_N,
   stage_sched_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_RUN, S_GAP, S_FIN
   } state_t;

   localparam logic [3:0] LastStg = 4'(NSTG - 1);

   state_t          state_q, state_d;
   logic [3:0]      stg_q, stg_d;
   logic            err_q, err_d;
   logic [NSTG-1:0] ena_q, ena_d;
   logic [3:0]      sel_q, sel_d;
   logic [RAMS-1:0] own_q, own_d;
   logic            busy_q, busy_d;
   logic            fdone_q, fdone_d;

   logic [NSTG-1:0] act;
   logic [NSTG-1:0] nxt_oh;
   logic [RAMS-1:0] own_nxt;
   logic            hit;
   logic            stray;
   logic            start_ok;

`ifdef STAGE_WDT_EN
   logic [23:0]     wdt_q, wdt_d;
   logic            to_q, to_d;
`else
   logic            unused_wdt;
   assign unused_wdt = ^WDT_LIMIT;
`endif

   // classify this cycle's done bits against the active stage
   always_comb begin
      act = '0;
      for (int s = 0; s < NSTG; s++)
         act[s] = (stg_q == 4'(s));
      hit      = |(bus.iDONE & act);
      stray    = |(bus.iDONE & ~act);
      start_ok = (state_q == S_IDLE) && bus.iSTART && !bus.iABORT;
   end

   // state register and all registered outputs
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         stg_q   <= '0;
         err_q   <= 1'b0;
         ena_q   <= '0;
         sel_q   <= '0;
         own_q   <= '0;
         busy_q  <= 1'b0;
         fdone_q <= 1'b0;
`ifdef STAGE_WDT_EN
         wdt_q   <= '0;
         to_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         stg_q   <= stg_d;
         err_q   <= err_d;
         ena_q   <= ena_d;
         sel_q   <= sel_d;
         own_q   <= own_d;
         busy_q  <= busy_d;
         fdone_q <= fdone_d;
`ifdef STAGE_WDT_EN
         wdt_q   <= wdt_d;
         to_q    <= to_d;
`endif
      end
   end

   // next state, stage index and sticky flags; abort overrides everything
   always_comb begin
      state_d = state_q;
      stg_d   = stg_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_LAUNCH;
               stg_d   = '0;
               err_d   = 1'b0;
            end
         end
         S_LAUNCH, S_RUN: begin
            if (hit) begin
               if (stg_q == LastStg) begin
                  state_d = S_FIN;
               end else begin
                  state_d = S_GAP;
                  stg_d   = stg_q + 4'd1;
               end
            end else begin
               state_d = S_RUN;
            end
         end
         S_GAP: state_d = S_LAUNCH;
         S_FIN: begin
            state_d = S_IDLE;
            stg_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            stg_d   = '0;
         end
      endcase
      if (stray || ((state_q == S_IDLE || state_q == S_FIN) && |bus.iDONE))
         err_d = 1'b1;
`ifdef STAGE_WDT_EN
      wdt_d = wdt_q;
      to_d  = to_q;
      if (start_ok)
         to_d = 1'b0;
      if (state_q == S_LAUNCH) begin
         wdt_d = '0;
      end else if (state_q == S_RUN && !hit) begin
         wdt_d = wdt_q + 24'd1;
         if (wdt_d == WDT_LIMIT) begin
            to_d    = 1'b1;
            state_d = S_IDLE;
            stg_d   = '0;
         end
      end
`endif
      if (bus.iABORT) begin
         state_d = S_IDLE;
         stg_d   = '0;
      end
   end

   // outputs for the upcoming state; table slice captured only on LAUNCH entry
   always_comb begin
      own_nxt = '0;
      nxt_oh  = '0;
      for (int s = 0; s < NSTG; s++) begin
         if (stg_d == 4'(s)) begin
            own_nxt   = bus.iOWN_TBL[s*RAMS +: RAMS];
            nxt_oh[s] = 1'b1;
         end
      end
      ena_d   = '0;
      sel_d   = stg_d;
      own_d   = '0;
      busy_d  = 1'b0;
      fdone_d = 1'b0;
      unique case (state_d)
         S_IDLE: sel_d = '0;
         S_LAUNCH: begin
            ena_d  = nxt_oh;
            own_d  = own_nxt;
            busy_d = 1'b1;
         end
         S_RUN: begin
            own_d  = own_q;
            busy_d = 1'b1;
         end
         S_GAP: busy_d = 1'b1;
         S_FIN: fdone_d = 1'b1;
         default: sel_d = '0;
      endcase
   end

   assign bus.oENA        = ena_q;
   assign bus.oSEL        = sel_q;
   assign bus.oOWN        = own_q;
   assign bus.oBUSY       = busy_q;
   assign bus.oFRAME_DONE = fdone_q;
   assign bus.oERR        = err_q;
`ifdef STAGE_WDT_EN
   assign bus.oTIMEOUT    = to_q;
`else
   assign bus.oTIMEOUT    = 1'b0;
`endif
endmodule

// File: tb/tb_stage_sched.sv
// tb_stage_sched: frame timelines built from stage lengths drive the DUT and
// carry the expected outputs for every cycle.
`timescale 1ns/1ps
module tb_stage_sched;
   localparam int NSTG = 3;
   localparam int RAMS = 4;
   localparam int TW   = NSTG * RAMS;

   typedef struct {
      logic            start, abort, acc, spur, tos, chk_sel;
      logic [NSTG-1:0] done;
      logic [TW-1:0]   tbl;
      logic [NSTG-1:0] ena;
      logic [3:0]      sel;
      logic [RAMS-1:0] own;
      logic            busy, fdone;
   } cyc_t;

   cyc_t q[$];
   int   checks = 0;
   int   errors = 0;
   logic err_m  = 1'b0;
   logic to_m   = 1'b0;
   logic iCLK   = 1'b0;
   logic iRST_N = 1'b0;

   always #5 iCLK = ~iCLK;

   stage_sched_if #(.NSTG(NSTG), .RAMS(RAMS)) bus ();

`ifdef STAGE_WDT_EN
   stage_sched #(.NSTG(NSTG), .RAMS(RAMS), .WDT_LIMIT(24'd16)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));
`else
   stage_sched #(.NSTG(NSTG), .RAMS(RAMS)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));
`endif

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
      end
   endtask

   function automatic cyc_t idle_c();
      cyc_t c;
      c.start = 0; c.abort = 0; c.acc = 0; c.spur = 0; c.tos = 0;
      c.chk_sel = 1; c.done = '0; c.tbl = TW'($urandom);
      c.ena = '0; c.sel = '0; c.own = '0; c.busy = 0; c.fdone = 0;
      return c;
   endfunction

   // one frame: start, then per stage LAUNCH + lens RUN cycles + GAP/FIN
   task automatic add_frame(input int lens[NSTG], input logic [TW-1:0] tbl,
                            input int sp_stg, input int sp_bit,
                            input int ab_stg, input int ab_j, input bit hold);
      cyc_t c;
      c = idle_c(); c.start = 1; c.acc = 1; c.tbl = tbl;
      q.push_back(c);
      for (int k = 0; k < NSTG; k++) begin
         for (int j = 0; j <= lens[k] + 1; j++) begin
            c = idle_c();
            c.start = hold;
            if (j <= lens[k]) begin
               if (j == 0) c.ena[k] = 1'b1;
               c.sel  = 4'(k);
               c.own  = tbl[k*RAMS +: RAMS];
               c.busy = 1;
               if (j == lens[k]) c.done[k] = 1'b1;
               if (k == sp_stg && j == 1 && lens[k] >= 2) begin
                  c.done[sp_bit] = 1'b1;
                  c.spur = 1;
               end
            end else if (k < NSTG - 1) begin
               c.sel = 4'(k + 1); c.busy = 1; c.tbl = tbl;
            end else begin
               c.fdone = 1; c.chk_sel = 0;
            end
            if (k == ab_stg && j == ab_j) begin
               c.abort = 1;
               q.push_back(c);
               q.push_back(idle_c());
               return;
            end
            q.push_back(c);
         end
      end
      q.push_back(idle_c());
   endtask

   task automatic run_q();
      cyc_t c;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(negedge iCLK);
         chk("ena", 32'(bus.oENA), 32'(c.ena));
         chk("own", 32'(bus.oOWN), 32'(c.own));
         chk("busy", 32'(bus.oBUSY), 32'(c.busy));
         chk("fdone", 32'(bus.oFRAME_DONE), 32'(c.fdone));
         chk("err", 32'(bus.oERR), 32'(err_m));
         chk("tmo", 32'(bus.oTIMEOUT), 32'(to_m));
         if (c.chk_sel) chk("sel", 32'(bus.oSEL), 32'(c.sel));
         bus.iSTART   = c.start;
         bus.iABORT   = c.abort;
         bus.iDONE    = c.done;
         bus.iOWN_TBL = c.tbl;
         if (c.acc) begin err_m = 0; to_m = 0; end
         if (c.spur) err_m = 1;
         if (c.tos) to_m = 1;
      end
   endtask

`ifdef STAGE_WDT_EN
   task automatic add_wdt();
      cyc_t c;
      logic [TW-1:0] tbl;
      tbl = TW'($urandom);
      c = idle_c(); c.start = 1; c.acc = 1; c.tbl = tbl;
      q.push_back(c);
      for (int j = 0; j <= 16; j++) begin
         c = idle_c();
         c.ena[0] = (j == 0);
         c.own = tbl[RAMS-1:0];
         c.busy = 1;
         if (j == 16) c.tos = 1;
         q.push_back(c);
      end
      q.push_back(idle_c());
      q.push_back(idle_c());
   endtask
`endif

   initial begin
      int ln[NSTG];
      cyc_t c;
      bus.iSTART = 0; bus.iABORT = 0; bus.iDONE = '0; bus.iOWN_TBL = '0;
      repeat (2) @(negedge iCLK);
      chk("rst_ena", 32'(bus.oENA), 0);
      chk("rst_sel", 32'(bus.oSEL), 0);
      chk("rst_own", 32'(bus.oOWN), 0);
      chk("rst_busy", 32'(bus.oBUSY), 0);
      chk("rst_fdone", 32'(bus.oFRAME_DONE), 0);
      chk("rst_err", 32'(bus.oERR), 0);
      chk("rst_tmo", 32'(bus.oTIMEOUT), 0);
      iRST_N = 1;
      q.push_back(idle_c());
      ln = '{5, 5, 5};
      add_frame(ln, 12'h9A5, -1, 0, -1, 0, 0);
      ln = '{5, 5, 5};
      add_frame(ln, 12'h393, 0, 2, -1, 0, 0);
      ln = '{3, 4, 2};
      add_frame(ln, 12'h5C1, -1, 0, -1, 0, 0);
      ln = '{3, 4, 2};
      add_frame(ln, 12'h7E2, -1, 0, 1, 4, 0);
      ln = '{0, 2, 0};
      add_frame(ln, 12'hA6F, -1, 0, -1, 0, 0);
      ln = '{2, 3, 1};
      add_frame(ln, 12'h1D4, -1, 0, -1, 0, 1);
`ifndef STAGE_WDT_EN
      ln = '{40, 1, 1};
      add_frame(ln, 12'h0F3, -1, 0, 0, 40, 0);
`endif
      for (int f = 0; f < 40; f++) begin
         int sp, ab, aj;
         for (int k = 0; k < NSTG; k++) ln[k] = $urandom_range(0, 6);
         sp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NSTG - 1) : -1;
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, NSTG - 1) : -1;
         aj = (ab >= 0) ? $urandom_range(0, ln[ab] + 1) : 0;
         add_frame(ln, TW'($urandom),
                   sp, (sp + $urandom_range(1, NSTG - 1)) % NSTG,
                   ab, aj, 1'($urandom_range(0, 1)));
         for (int i = $urandom_range(0, 2); i > 0; i--) begin
            c = idle_c();
            if ($urandom_range(0, 4) == 0) begin
               c.done = NSTG'($urandom_range(1, (1 << NSTG) - 1));
               c.spur = 1;
            end
            q.push_back(c);
         end
      end
`ifdef STAGE_WDT_EN
      add_wdt();
      ln = '{1, 1, 1};
      add_frame(ln, 12'h321, -1, 0, -1, 0, 0);
`endif
      run_q();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
